// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// master: requester side (drives requests and enable).
// slave : arbiter side (drives the grant outputs).
interface rr_arbiter_4_if;
    logic       enable_in;
    logic [3:0] req_in;
    logic [3:0] grant_out;
    logic [1:0] grant_idx_out;
    logic       grant_valid_out;
    logic       timeout_out;

    modport master (
        output enable_in,
        output req_in,
        input  grant_out,
        input  grant_idx_out,
        input  grant_valid_out,
        input  timeout_out
    );

    modport slave (
        input  enable_in,
        input  req_in,
        output grant_out,
        output grant_idx_out,
        output grant_valid_out,
        output timeout_out
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// A grant persists while its request stays high, for at most MAX_HOLD cycles.
// Every release returns through IDLE, so grants are never back-to-back.
// The released index becomes the lowest priority for the next arbitration.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  arb
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Last hold count value before the grant is forcibly released.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        grant_r;
    logic [3:0]        grant_s;
    logic [1:0]        grant_idx_r;
    logic [1:0]        grant_idx_s;
    logic              valid_r;
    logic              valid_s;
    logic              timeout_r;
    logic              timeout_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic [1:0]        last_ptr_r;
    logic [1:0]        last_ptr_s;
    logic [1:0]        winner_s;

    // One-hot decode, same encoding as the 2-to-4 select decoder.
    function automatic logic [3:0] decode_idx(input logic [1:0] idx);
        logic [3:0] onehot;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    // First set request scanning last+1 .. last+4 (mod 4). Scanning from the
    // lowest priority upwards lets the highest-priority hit overwrite earlier ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] win;
        logic [1:0] cand;
        win = last + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            win  = req[cand] ? cand : win;
        end
        return win;
    endfunction

    assign winner_s = rr_pick(arb.req_in, last_ptr_r);

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        grant_idx_s = grant_idx_r;
        valid_s     = valid_r;
        timeout_s   = 1'b0;
        hold_cnt_s  = hold_cnt_r;
        last_ptr_s  = last_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (arb.enable_in && (arb.req_in != 4'b0000)) begin
                    state_s     = ST_GRANT;
                    grant_idx_s = winner_s;
                    grant_s     = decode_idx(winner_s);
                    valid_s     = 1'b1;
                    hold_cnt_s  = {HOLD_W{1'b0}};
                end else begin
                    state_s     = ST_IDLE;
                    grant_s     = 4'b0000;
                    valid_s     = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!arb.req_in[grant_idx_r]) begin
                    // Requester let go; a drop coinciding with the hold limit lands here too.
                    state_s    = ST_IDLE;
                    grant_s    = 4'b0000;
                    valid_s    = 1'b0;
                    last_ptr_s = grant_idx_r;
                    hold_cnt_s = {HOLD_W{1'b0}};
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = ST_IDLE;
                    grant_s    = 4'b0000;
                    valid_s    = 1'b0;
                    last_ptr_s = grant_idx_r;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    timeout_s  = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                grant_s    = 4'b0000;
                valid_s    = 1'b0;
                hold_cnt_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 at top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= 4'b0000;
            grant_idx_r <= 2'b00;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            last_ptr_r  <= 2'b11;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            grant_idx_r <= grant_idx_s;
            valid_r     <= valid_s;
            timeout_r   <= timeout_s;
            hold_cnt_r  <= hold_cnt_s;
            last_ptr_r  <= last_ptr_s;
        end
    end

    assign arb.grant_out       = grant_r;
    assign arb.grant_idx_out   = grant_idx_r;
    assign arb.grant_valid_out = valid_r;
    assign arb.timeout_out     = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: directed stimulus pushes hand-computed
// grant records (vector, index, first cycle, length, timeout at release);
// a negedge monitor pops and checks each grant as the DUT presents it.
module tb_rr_arbiter_4;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        int         start;
        int         len;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    logic active[2] = '{1'b0, 1'b0};
    logic pv[2]     = '{1'b0, 1'b0};
    int   run[2]    = '{0, 0};

    rr_arbiter_4_if if8();
    rr_arbiter_4_if if1();

    rr_arbiter_4 #(.MAX_HOLD(8), .HOLD_W(4)) dut8 (.clk(clk), .rst(rst), .arb(if8.slave));
    rr_arbiter_4 #(.MAX_HOLD(1), .HOLD_W(4)) dut1 (.clk(clk), .rst(rst), .arb(if1.slave));

    always #5 clk = ~clk;

    // Cycle label: value seen at a negedge names the cycle after that posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input int d, input logic [3:0] g, input logic [1:0] ix,
                                input int start, input int len, input logic tmo);
        exp_t e;
        e.grant = g;
        e.idx   = ix;
        e.start = start;
        e.len   = len;
        e.tmo   = tmo;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d, input logic [3:0] g, input logic [1:0] ix,
                       input logic v, input logic t);
        logic fall;
        int   qs;
        fall = !v && pv[d];
        qs   = (d == 0) ? q0.size() : q1.size();
        chk($sformatf("d%0d_valid_vs_grant", d), {31'b0, v}, {31'b0, (g != 4'b0000)});
        chk($sformatf("d%0d_onehot0", d), {31'b0, $onehot0(g)}, 32'd1);
        if (v) chk($sformatf("d%0d_decode", d), {28'b0, g}, 32'd1 << ix);
        if (v && !pv[d]) begin
            run[d] = 1;
            if (qs == 0) begin
                active[d] = 1'b0;
                chk($sformatf("d%0d_unexpected_grant", d), {28'b0, g}, 32'd0);
            end else begin
                cur[d]    = (d == 0) ? q0.pop_front() : q1.pop_front();
                active[d] = 1'b1;
                chk($sformatf("d%0d_grant", d), {28'b0, g}, {28'b0, cur[d].grant});
                chk($sformatf("d%0d_idx", d), {30'b0, ix}, {30'b0, cur[d].idx});
                chk($sformatf("d%0d_start_cycle", d), cyc, cur[d].start);
            end
        end else if (v) begin
            run[d]++;
            if (active[d]) chk($sformatf("d%0d_grant_stable", d), {28'b0, g}, {28'b0, cur[d].grant});
        end else if (fall && active[d]) begin
            chk($sformatf("d%0d_grant_len", d), run[d], cur[d].len);
            chk($sformatf("d%0d_timeout_at_release", d), {31'b0, t}, {31'b0, cur[d].tmo});
            active[d] = 1'b0;
        end
        if (t && !fall) chk($sformatf("d%0d_stray_timeout", d), {31'b0, t}, 32'd0);
        pv[d] = v;
    endtask

    // Monitor: samples both arbiters mid-cycle and scores each grant.
    always @(negedge clk) begin
        mon(0, if8.grant_out, if8.grant_idx_out, if8.grant_valid_out, if8.timeout_out);
        mon(1, if1.grant_out, if1.grant_idx_out, if1.grant_valid_out, if1.timeout_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Directed stimulus; expectations are computed by hand relative to cyc.
    initial begin
        logic [3:0] t2_grant [5];
        int a;
        int b;
        t2_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        if8.enable_in = 1'b1;
        if8.req_in    = 4'b0000;
        if1.enable_in = 1'b1;
        if1.req_in    = 4'b0000;
        tick();
        tick();
        chk("rst_grant", {28'b0, if8.grant_out}, 32'd0);
        chk("rst_valid", {31'b0, if8.grant_valid_out}, 32'd0);
        chk("rst_idx", {30'b0, if8.grant_idx_out}, 32'd0);
        chk("rst_timeout", {31'b0, if8.timeout_out}, 32'd0);
        chk("rst_grant_d1", {28'b0, if1.grant_out}, 32'd0);
        rst = 1'b0;
        tick();

        // Single requester: grant one cycle after the request, gone after drop.
        a = cyc;
        if8.req_in = 4'b0001;
        expect_grant(0, 4'b0001, 2'd0, a + 1, 3, 1'b0);
        repeat (3) tick();
        if8.req_in = 4'b0000;
        tick();
        tick();
        chk("idx_kept_after_release", {30'b0, if8.grant_idx_out}, 32'd0);
        // Request withdrawn right after arbitration still yields a 1-cycle grant.
        a = cyc;
        if8.req_in = 4'b0001;
        expect_grant(0, 4'b0001, 2'd0, a + 1, 1, 1'b0);
        tick();
        if8.req_in = 4'b0000;
        tick();
        tick();

        // All four requesting: rotation, 8-cycle holds, timeout per grant;
        // the last drop coincides with the hold limit and is a normal release.
        do_reset();
        a = cyc;
        if8.req_in = 4'b1111;
        for (int k = 0; k < 5; k++)
            expect_grant(0, t2_grant[k], 2'(k), a + 1 + 9 * k, 8, (k < 4));
        repeat (44) tick();
        if8.req_in = 4'b0000;
        repeat (3) tick();

        // Requester 1 finishes, so 0110 goes to 2 first, then 1.
        a = cyc;
        if8.req_in = 4'b0010;
        expect_grant(0, 4'b0010, 2'd1, a + 1, 2, 1'b0);
        tick();
        tick();
        if8.req_in = 4'b0000;
        tick();
        tick();
        b = cyc;
        if8.req_in = 4'b0110;
        expect_grant(0, 4'b0100, 2'd2, b + 1, 3, 1'b0);
        repeat (3) tick();
        if8.req_in = 4'b0010;
        expect_grant(0, 4'b0010, 2'd1, b + 5, 3, 1'b0);
        repeat (4) tick();
        if8.req_in = 4'b0000;
        tick();
        tick();

        // Enable low blocks new grants but does not cut an active one short.
        if8.enable_in = 1'b0;
        a = cyc;
        if8.req_in = 4'b1000;
        repeat (5) tick();
        if8.enable_in = 1'b1;
        expect_grant(0, 4'b1000, 2'd3, a + 6, 4, 1'b0);
        tick();
        if8.enable_in = 1'b0;
        repeat (3) tick();
        if8.req_in = 4'b0000;
        tick();
        if8.enable_in = 1'b1;
        tick();

        // Asynchronous reset mid-grant, then priority restarts at requester 0.
        a = cyc;
        if8.req_in = 4'b0100;
        expect_grant(0, 4'b0100, 2'd2, a + 1, 3, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("async_rst_grant", {28'b0, if8.grant_out}, 32'd0);
        chk("async_rst_valid", {31'b0, if8.grant_valid_out}, 32'd0);
        chk("async_rst_idx", {30'b0, if8.grant_idx_out}, 32'd0);
        if8.req_in = 4'b0101;
        tick();
        rst = 1'b0;
        b = cyc;
        expect_grant(0, 4'b0001, 2'd0, b + 1, 2, 1'b0);
        tick();
        tick();
        if8.req_in = 4'b0000;
        tick();
        tick();

        // MAX_HOLD = 1: alternating single-cycle grants with timeouts.
        a = cyc;
        if1.req_in = 4'b0011;
        expect_grant(1, 4'b0001, 2'd0, a + 1, 1, 1'b1);
        expect_grant(1, 4'b0010, 2'd1, a + 3, 1, 1'b1);
        expect_grant(1, 4'b0001, 2'd0, a + 5, 1, 1'b1);
        expect_grant(1, 4'b0010, 2'd1, a + 7, 1, 1'b0);
        repeat (7) tick();
        if1.req_in = 4'b0000;
        repeat (3) tick();

        chk("sb_drain_d0", q0.size(), 32'd0);
        chk("sb_drain_d1", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
